ysyx_22041752_lsu: RTL and testbench

YSYX_22041752_LSU -- requirements
Module: ysyx_22041752_lsu

---
 rtl/ysyx_22041752_lsu_pkg.sv | 43 ++++
 rtl/ysyx_22041752_lsu_align.sv | 43 ++++
 rtl/ysyx_22041752_lsu.sv | 151 +++++++++++++++
 tb/tb_ysyx_22041752_lsu.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041752_lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - access size encodings (SZ_B/H/W/D)
//   - FSM state encoding
//   - helpers for byte-mask and alignment decisions
package ysyx_22041752_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  // Right-aligned byte mask covering 2^size bytes.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // True when the byte offset is not a multiple of the access size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    logic r;
    case (size)
      SZ_B:    r = 1'b0;
      SZ_H:    r = off[0];
      SZ_W:    r = |off[1:0];
      default: r = |off;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ysyx_22041752_lsu_align.sv
// Combinational lane logic for the LSU.
//   off_i   : byte offset within the dword (addr[2:0])
//   size_i  : access size encoding
//   uns_i   : zero-extend load result when 1
//   wdata_i : right-aligned store data
//   rdata_i : raw dword from memory
//   wdata_o : store data shifted into its byte lanes
//   wstrb_o : byte strobes, truncated at the dword boundary
//   rdata_o : extracted and sign/zero-extended load data
module ysyx_22041752_lsu_align
  import ysyx_22041752_lsu_pkg::*;
(
  input  logic [2:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] rdata_i,
  output logic [63:0] wdata_o,
  output logic [7:0]  wstrb_o,
  output logic [63:0] rdata_o
);

  logic [5:0]  sh_bits;
  logic [63:0] rdata_sh;

  assign sh_bits  = {off_i, 3'b000};
  assign wdata_o  = wdata_i << sh_bits;
  // 8-bit shift drops strobes past byte 7 rather than wrapping them.
  assign wstrb_o  = size_mask(size_i) << off_i;
  // Right shift zero-fills, so bytes beyond the dword read as zero.
  assign rdata_sh = rdata_i >> sh_bits;

  always_comb begin
    rdata_o = rdata_sh;
    case (size_i)
      SZ_B:    rdata_o = {{56{~uns_i & rdata_sh[7]}},  rdata_sh[7:0]};
      SZ_H:    rdata_o = {{48{~uns_i & rdata_sh[15]}}, rdata_sh[15:0]};
      SZ_W:    rdata_o = {{32{~uns_i & rdata_sh[31]}}, rdata_sh[31:0]};
      default: rdata_o = rdata_sh;
    endcase
  end

endmodule

// File: rtl/ysyx_22041752_lsu.sv
// Load/store unit: accepts one access from execute, issues it to data
// memory, waits for completion and returns extended load data.
//
// Optional feature: define YSYX_22041752_LSU_MISALIGN_CHK_EN to reject
// misaligned accesses with resp_err=1 and no memory request. Without it
// resp_err is tied low and misaligned accesses go to memory with lanes
// truncated at the dword boundary.
//
// Ports:
//   clk, reset                   clock, async active-high reset
//   req_valid/req_ready          request handshake from execute
//   req_wen/size/uns/addr/wdata  access description
//   resp_valid/resp_ready        completion handshake to writeback
//   resp_rdata, resp_err         load result (0 for stores), misalign flag
//   dmem_req/dmem_gnt            memory request handshake
//   dmem_we/addr/wdata/wstrb     memory request payload (dword aligned)
//   dmem_rvalid/dmem_rdata       memory completion
module ysyx_22041752_lsu
  import ysyx_22041752_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_uns,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        dmem_req,
  input  logic        dmem_gnt,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_wstrb,
  input  logic        dmem_rvalid,
  input  logic [63:0] dmem_rdata
);

  lsu_state_e  state_q, state_d;
  logic [2:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        we_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [7:0]  wstrb_q;
  logic [63:0] rdata_q;

  logic        accept;
  logic        chk_fail;
  logic        idle;
  logic [2:0]  al_off;
  logic [1:0]  al_size;
  logic        al_uns;
  logic [63:0] al_wdata;
  logic [7:0]  al_wstrb;
  logic [63:0] al_rdata;

  assign idle   = (state_q == ST_IDLE);
  assign accept = req_valid & idle;

  // One align instance serves both directions: in IDLE it shapes the
  // incoming store, afterwards it extracts the load using latched fields.
  assign al_off  = idle ? req_addr[2:0] : off_q;
  assign al_size = idle ? req_size      : size_q;
  assign al_uns  = idle ? req_uns       : uns_q;

  ysyx_22041752_lsu_align u_align (
    .off_i   (al_off),
    .size_i  (al_size),
    .uns_i   (al_uns),
    .wdata_i (req_wdata),
    .rdata_i (dmem_rdata),
    .wdata_o (al_wdata),
    .wstrb_o (al_wstrb),
    .rdata_o (al_rdata)
  );

`ifdef YSYX_22041752_LSU_MISALIGN_CHK_EN
  logic err_q;

  assign chk_fail = is_misaligned(req_size, req_addr[2:0]);
  assign resp_err = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= chk_fail;
    end
  end
`else
  assign chk_fail = 1'b0;
  assign resp_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid)   state_d = chk_fail ? ST_RESP : ST_REQ;
      ST_REQ:  if (dmem_gnt)    state_d = ST_WAIT;
      ST_WAIT: if (dmem_rvalid) state_d = ST_RESP;
      ST_RESP: if (resp_ready)  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      off_q   <= 3'd0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      wstrb_q <= 8'd0;
      rdata_q <= 64'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        off_q   <= req_addr[2:0];
        size_q  <= req_size;
        uns_q   <= req_uns;
        we_q    <= req_wen;
        addr_q  <= {req_addr[63:3], 3'b000};
        wdata_q <= al_wdata;
        wstrb_q <= al_wstrb;
        rdata_q <= 64'd0;
      end
      if ((state_q == ST_WAIT) && dmem_rvalid) begin
        rdata_q <= we_q ? 64'd0 : al_rdata;
      end
    end
  end

  assign req_ready  = idle;
  assign dmem_req   = (state_q == ST_REQ);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_wstrb = wstrb_q;

endmodule

// File: tb/tb_ysyx_22041752_lsu.sv
module tb_ysyx_22041752_lsu;
  import ysyx_22041752_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wen, req_uns;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic        dmem_req, dmem_gnt, dmem_we, dmem_rvalid;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_wstrb;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    logic        wen;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] mrdata;
    int          gw;
    int          rw;
    logic [63:0] e_rdata;
    logic        e_err;
    int          e_lat;
    logic [7:0]  e_wstrb;
    logic [63:0] e_wdata;
  } txn_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  ysyx_22041752_lsu dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wen     (req_wen),
    .req_size    (req_size),
    .req_uns     (req_uns),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .dmem_req    (dmem_req),
    .dmem_gnt    (dmem_gnt),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_wstrb  (dmem_wstrb),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk(input logic wen, input logic [1:0] size, input logic uns,
                              input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [63:0] mrdata, input int gw, input int rw,
                              input logic [63:0] e_rdata, input logic e_err, input int e_lat,
                              input logic [7:0] e_wstrb, input logic [63:0] e_wdata);
    txn_t t;
    t.wen = wen; t.size = size; t.uns = uns; t.addr = addr; t.wdata = wdata;
    t.mrdata = mrdata; t.gw = gw; t.rw = rw; t.e_rdata = e_rdata; t.e_err = e_err;
    t.e_lat = e_lat; t.e_wstrb = e_wstrb; t.e_wdata = e_wdata;
    return t;
  endfunction

  // Drives one access and plays the memory side: grant after t.gw stall
  // cycles, completion in the cycle after the grant edge.
  task automatic run_txn(input string name, input txn_t t);
    exp_t e;
    bit   done, rv_pend, seen_req, seen_resp;
    int   n, gw, rw;
    done = 0; rv_pend = 0; seen_req = 0; seen_resp = 0; n = 0; gw = 0; rw = 0;
    @(negedge clk);
    chk({name, ":req_ready_idle"}, req_ready, 1'b1);
    req_valid = 1'b1; req_wen = t.wen; req_size = t.size; req_uns = t.uns;
    req_addr = t.addr; req_wdata = t.wdata;
    e.rdata = t.e_rdata; e.err = t.e_err; e.lat = t.e_lat;
    sb.push_back(e);
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      req_valid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
      chk({name, ":req_ready_busy"}, req_ready, 1'b0);
      if (rv_pend) begin
        dmem_rvalid = 1'b1; dmem_rdata = t.mrdata; rv_pend = 0;
      end
      if (dmem_req) begin
        seen_req = 1;
        chk({name, ":dmem_addr"},  dmem_addr, {t.addr[63:3], 3'b000});
        chk({name, ":dmem_we"},    dmem_we, t.wen);
        chk({name, ":dmem_wstrb"}, dmem_wstrb, t.e_wstrb);
        if (t.wen) chk({name, ":dmem_wdata"}, dmem_wdata, t.e_wdata);
        if (gw >= t.gw) begin
          dmem_gnt = 1'b1; rv_pend = 1;
        end else begin
          gw++;
        end
      end
      if (resp_valid) begin
        if (!seen_resp) begin
          seen_resp = 1;
          chk({name, ":latency"}, n, sb[0].lat);
        end
        chk({name, ":resp_rdata"}, resp_rdata, sb[0].rdata);
        chk({name, ":resp_err"},   resp_err, sb[0].err);
        if (rw >= t.rw) begin
          resp_ready = 1'b1; done = 1;
        end else begin
          rw++;
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL %s:timeout observed=no_response expected=response", name);
    end
    @(negedge clk);
    resp_ready = 1'b0;
    chk({name, ":resp_valid_after"}, resp_valid, 1'b0);
    chk({name, ":req_ready_after"},  req_ready, 1'b1);
    if (t.e_err) chk({name, ":no_dmem_req"}, seen_req, 1'b0);
    void'(sb.pop_front());
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 0; req_wen = 0; req_size = SZ_B; req_uns = 0; req_addr = '0; req_wdata = '0;
    resp_ready = 0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst:req_ready",  req_ready, 1'b1);
    chk("rst:resp_valid", resp_valid, 1'b0);
    chk("rst:dmem_req",   dmem_req, 1'b0);
    chk("rst:resp_rdata", resp_rdata, 64'd0);
    chk("rst:resp_err",   resp_err, 1'b0);
    chk("rst:dmem_wstrb", dmem_wstrb, 8'd0);
    chk("rst:dmem_addr",  dmem_addr, 64'd0);
    reset = 1'b0;

    run_txn("lb3",  mk(0, SZ_B, 0, 64'h80000003, 0, 64'h1122334455667788, 0, 0,
                       64'h0000000000000055, 0, 3, 8'h08, 0));
    run_txn("lb0",  mk(0, SZ_B, 0, 64'h80000000, 0, 64'h1122334455667788, 0, 0,
                       64'hFFFFFFFFFFFFFF88, 0, 3, 8'h01, 0));
    run_txn("sh6",  mk(1, SZ_H, 0, 64'h80000006, 64'hABCD, 64'hDEADBEEFDEADBEEF, 0, 0,
                       64'd0, 0, 3, 8'hC0, 64'hABCD000000000000));
    run_txn("lwu4", mk(0, SZ_W, 1, 64'h80000004, 0, 64'h8000000000000000, 0, 0,
                       64'h0000000080000000, 0, 3, 8'hF0, 0));
    run_txn("lw4",  mk(0, SZ_W, 0, 64'h80000004, 0, 64'h8000000000000000, 0, 0,
                       64'hFFFFFFFF80000000, 0, 3, 8'hF0, 0));
    run_txn("ld8",  mk(0, SZ_D, 0, 64'h80000008, 0, 64'hCAFEBABE12345678, 0, 0,
                       64'hCAFEBABE12345678, 0, 3, 8'hFF, 0));
    run_txn("sd",   mk(1, SZ_D, 0, 64'h80000010, 64'h0123456789ABCDEF, 64'h55, 0, 0,
                       64'd0, 0, 3, 8'hFF, 64'h0123456789ABCDEF));
    run_txn("sb5",  mk(1, SZ_B, 0, 64'h80000005, 64'hFFFFFFFFFFFFFF5A, 0, 0, 0,
                       64'd0, 0, 3, 8'h20, 64'hFFFF5A0000000000));
    run_txn("lh2",  mk(0, SZ_H, 0, 64'h80000002, 0, 64'h00000000ABCD0000, 0, 0,
                       64'hFFFFFFFFFFFFABCD, 0, 3, 8'h0C, 0));
    run_txn("lhu2", mk(0, SZ_H, 1, 64'h80000002, 0, 64'h00000000ABCD0000, 0, 0,
                       64'h000000000000ABCD, 0, 3, 8'h0C, 0));
    run_txn("bp",   mk(0, SZ_W, 0, 64'h80000000, 0, 64'h000000007FFFFFFF, 3, 5,
                       64'h000000007FFFFFFF, 0, 6, 8'h0F, 0));
`ifdef YSYX_22041752_LSU_MISALIGN_CHK_EN
    run_txn("mis2", mk(0, SZ_W, 0, 64'h80000002, 0, 64'h1122334455667788, 0, 2,
                       64'd0, 1, 1, 8'h00, 0));
    run_txn("mis6", mk(0, SZ_W, 0, 64'h80000006, 0, 64'h1122334455667788, 0, 0,
                       64'd0, 1, 1, 8'h00, 0));
`else
    run_txn("mis2", mk(0, SZ_W, 0, 64'h80000002, 0, 64'h1122334455667788, 0, 2,
                       64'h0000000033445566, 0, 3, 8'h3C, 0));
    run_txn("mis6", mk(0, SZ_W, 0, 64'h80000006, 0, 64'h1122334455667788, 0, 0,
                       64'h0000000000001122, 0, 3, 8'hC0, 0));
`endif

    // Reset in WAIT, then a stray completion from the aborted access.
    @(negedge clk);
    req_valid = 1'b1; req_wen = 0; req_size = SZ_D; req_uns = 0;
    req_addr = 64'h80000020; req_wdata = '0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rwait:in_req", dmem_req, 1'b1);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    chk("rwait:req_ready_wait", req_ready, 1'b0);
    chk("rwait:dmem_req_wait",  dmem_req, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("rwait:req_ready",  req_ready, 1'b1);
    chk("rwait:resp_valid", resp_valid, 1'b0);
    chk("rwait:dmem_req",   dmem_req, 1'b0);
    chk("rwait:dmem_addr",  dmem_addr, 64'd0);
    chk("rwait:dmem_wstrb", dmem_wstrb, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 64'h1234;
    @(negedge clk);
    dmem_rvalid = 1'b0; dmem_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray:resp_valid", resp_valid, 1'b0);
      chk("stray:req_ready",  req_ready, 1'b1);
    end
    chk("stray:resp_rdata", resp_rdata, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
